ex_muldiv: RTL and testbench



---
 rtl/ex_muldiv_pkg.sv | 27 ++
 rtl/ex_muldiv_if.sv | 29 ++
 rtl/ex_muldiv_md_iter_core.sv | 48 ++++
 rtl/ex_muldiv.sv | 156 +++++++++++++++
 tb/tb_ex_muldiv.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared opcodes, funct3 codes and FSM encodings for the RV32M execute unit.
package ex_muldiv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int MD_CNT_W = 6;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/ex_muldiv_if.sv
// ID/EX-to-muldiv bus: instruction fields and operands in, stall and write-back out.
interface ex_muldiv_if;

    logic [6:0]  idex2ex_opcode_i;
    logic [2:0]  idex2ex_funct3_i;
    logic [31:0] idex2ex_id_ins_i;
    logic [31:0] idex2ex_source1_i;
    logic [31:0] idex2ex_source2_i;
    logic [4:0]  idex2ex_rd_addr_i;
    logic        cu2md_flush_i;
    logic        md2cu_stall_o;
    logic [31:0] md2ex_result_o;
    logic [4:0]  md2ex_rd_addr_o;
    logic        md2ex_we_o;
    logic        md2ex_busy_o;

    modport master (
        output idex2ex_opcode_i, idex2ex_funct3_i, idex2ex_id_ins_i,
               idex2ex_source1_i, idex2ex_source2_i, idex2ex_rd_addr_i, cu2md_flush_i,
        input  md2cu_stall_o, md2ex_result_o, md2ex_rd_addr_o, md2ex_we_o, md2ex_busy_o
    );

    modport slave (
        input  idex2ex_opcode_i, idex2ex_funct3_i, idex2ex_id_ins_i,
               idex2ex_source1_i, idex2ex_source2_i, idex2ex_rd_addr_i, cu2md_flush_i,
        output md2cu_stall_o, md2ex_result_o, md2ex_rd_addr_o, md2ex_we_o, md2ex_busy_o
    );

endinterface

// File: rtl/ex_muldiv_md_iter_core.sv
// Unsigned radix-2 datapath: shift-add multiply or restoring divide, one step per enabled cycle.
// acc_step is the accumulator after the current step so the caller can capture the last one.
module ex_muldiv_md_iter_core #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    output logic [2*XLEN-1:0] acc_step
);

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic              div_mode;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_diff;

    // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
        if (!div_mode)
            acc_step = {mul_sum, acc[XLEN-1:1]};
        else if (!div_diff[XLEN])
            acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_step = {acc[2*XLEN-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!rest) begin
            acc      <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            div_mode <= is_div;
            opnd     <= is_div ? op_b : op_a;
            acc      <= {{XLEN{1'b0}}, (is_div ? op_a : op_b)};
        end else if (step) begin
            acc <= acc_step;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// RV32M execute-stage multiply/divide: iterative, stalls the front of the pipeline until done.
// IDLE | wait for an M instruction  ;  CALC | 32 radix-2 steps  ;  DONE | one-cycle write-back
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic        clk,
    input  logic        rest,
    ex_muldiv_if.slave  bus
);

    md_state_e         state;
    md_op_e            op_in;
    md_op_e            op_r;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   src_a;
    logic [XLEN-1:0]   src_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN-1:0]   special_res;
    logic [XLEN-1:0]   final_res;
    logic [XLEN-1:0]   result_r;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod;
    logic [4:0]        rd_r;
    logic [4:0]        rd_out;
    logic              neg_q_r;
    logic              neg_r_r;
    logic              we_r;
    logic              is_md;
    logic              start;
    logic              flush;
    logic              a_neg;
    logic              b_neg;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic              core_step;
    logic              unused_ins;

    assign src_a      = bus.idex2ex_source1_i;
    assign src_b      = bus.idex2ex_source2_i;
    assign flush      = bus.cu2md_flush_i;
    assign op_in      = md_op_e'(bus.idex2ex_funct3_i);
    assign unused_ins = ^bus.idex2ex_id_ins_i[24:0];

    assign is_md = (bus.idex2ex_opcode_i == OPCODE_OP) &&
                   (bus.idex2ex_id_ins_i[31:25] == FUNCT7_MULDIV);
    assign start = is_md && (state == MD_IDLE) && !flush;

    always_comb begin
        a_neg    = (op_in inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM}) && src_a[XLEN-1];
        b_neg    = (op_in inside {F3_MULH, F3_DIV, F3_REM}) && src_b[XLEN-1];
        mag_a    = a_neg ? -src_a : src_a;
        mag_b    = b_neg ? -src_b : src_b;
        div_zero = bus.idex2ex_funct3_i[2] && (src_b == '0);
        div_ovf  = (op_in == F3_DIV || op_in == F3_REM) &&
                   (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
        special  = div_zero || div_ovf;
        // funct3[1] separates REM/REMU from DIV/DIVU
        if (div_zero)
            special_res = bus.idex2ex_funct3_i[1] ? src_a : '1;
        else
            special_res = bus.idex2ex_funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    always_comb begin
        prod = neg_q_r ? -acc_step : acc_step;
        case (op_r)
            F3_MUL:                      final_res = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             final_res = neg_q_r ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
            default:                     final_res = neg_r_r ? -acc_step[2*XLEN-1:XLEN]
                                                             : acc_step[2*XLEN-1:XLEN];
        endcase
    end

    assign core_step = (state == MD_CALC) && !flush;

    ex_muldiv_md_iter_core #(.XLEN(XLEN)) u_core (
        .clk      (clk),
        .rest     (rest),
        .load     (start),
        .step     (core_step),
        .is_div   (bus.idex2ex_funct3_i[2]),
        .op_a     (mag_a),
        .op_b     (mag_b),
        .acc_step (acc_step)
    );

    always_ff @(posedge clk) begin
        if (!rest) begin
            state    <= MD_IDLE;
            op_r     <= F3_MUL;
            cnt      <= '0;
            rd_r     <= '0;
            rd_out   <= '0;
            result_r <= '0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            we_r     <= 1'b0;
        end else if (flush) begin
            state <= MD_IDLE;
            cnt   <= '0;
            we_r  <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    we_r <= 1'b0;
                    if (start) begin
                        op_r    <= op_in;
                        rd_r    <= bus.idex2ex_rd_addr_i;
                        neg_q_r <= a_neg ^ b_neg;
                        neg_r_r <= a_neg;
                        cnt     <= '0;
                        if (special) begin
                            state    <= MD_DONE;
                            result_r <= special_res;
                            rd_out   <= bus.idex2ex_rd_addr_i;
                            we_r     <= (bus.idex2ex_rd_addr_i != '0);
                        end else begin
                            state <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        state    <= MD_DONE;
                        result_r <= final_res;
                        rd_out   <= rd_r;
                        we_r     <= (rd_r != '0);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                MD_DONE: begin
                    state <= MD_IDLE;
                    we_r  <= 1'b0;
                end
                default: begin
                    state <= MD_IDLE;
                    we_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.md2cu_stall_o   = rest && !flush && (start || (state == MD_CALC));
    assign bus.md2ex_we_o      = rest && !flush && we_r;
    assign bus.md2ex_busy_o    = (state != MD_IDLE);
    assign bus.md2ex_result_o  = result_r;
    assign bus.md2ex_rd_addr_o = rd_out;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed test-plan vectors, flush/reset scenarios and
// randomized operations against a plain-arithmetic RV32M reference model.
module tb_ex_muldiv;

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] F7_M    = 7'b0000001;
    localparam logic [6:0] F7_BASE = 7'b0000000;

    logic clk  = 1'b0;
    logic rest = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    ex_muldiv_if mif ();

    ex_muldiv dut (
        .clk  (clk),
        .rest (rest),
        .bus  (mif.slave)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          stalls;
    } vec_t;

    vec_t plan [12];

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ref_result = '0;
        case (f3)
            3'd0: begin p = sa * sb; ref_result = p[31:0];  end
            3'd1: begin p = sa * sb; ref_result = p[63:32]; end
            3'd2: begin p = sa * ub; ref_result = p[63:32]; end
            3'd3: begin p = ua * ub; ref_result = p[63:32]; end
            3'd4: ref_result = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'd5: ref_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: ref_result = (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: ref_result = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit ref_special(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        bit signed_div;
        signed_div  = (f3 == 3'd4) || (f3 == 3'd6);
        ref_special = f3[2] && ((b == 0) ||
                      (signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       pick = 32'h0;
            1:       pick = 32'h1;
            2:       pick = 32'hFFFF_FFFF;
            3:       pick = 32'h8000_0000;
            4:       pick = 32'($urandom_range(0, 255));
            default: pick = $urandom;
        endcase
    endfunction

    task automatic drive(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        mif.idex2ex_opcode_i  = opc;
        mif.idex2ex_funct3_i  = f3;
        mif.idex2ex_id_ins_i  = {f7, 5'd2, 5'd1, f3, rd, opc};
        mif.idex2ex_source1_i = a;
        mif.idex2ex_source2_i = b;
        mif.idex2ex_rd_addr_i = rd;
        mif.cu2md_flush_i     = 1'b0;
    endtask

    task automatic bubble();
        drive(OPC_IMM, F7_BASE, 3'd0, 32'h0, 32'h0, 5'd0);
    endtask

    // Present one instruction, hold it while stalled, then replace it with a bubble.
    task automatic do_op(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         output int stalls, output int wes, output int we_cyc,
                         output logic [31:0] res, output logic [4:0] rdo, output logic busy_first);
        int drop;
        drop = 0; stalls = 0; wes = 0; we_cyc = 0; res = '0; rdo = '0; busy_first = 1'b1;
        @(posedge clk); #1;
        drive(opc, f7, f3, a, b, rd);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) busy_first = mif.md2ex_busy_o;
            if (mif.md2cu_stall_o) stalls++;
            if (mif.md2ex_we_o) begin
                wes++;
                we_cyc = c;
                res    = mif.md2ex_result_o;
                rdo    = mif.md2ex_rd_addr_o;
            end
            if (drop != 0 && c >= drop + 2) break;
            if (!mif.md2cu_stall_o && drop == 0) begin
                drop = c;
                @(posedge clk); #1;
                bubble();
            end
        end
    endtask

    task automatic test_reset();
        rest = 1'b0;
        drive(OPC_OP, F7_M, 3'd0, 32'd3, 32'd4, 5'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (mif.md2cu_stall_o !== 1'b0) $display("FAIL reset_stall got %b exp 0", mif.md2cu_stall_o); else n_pass++;
        n_checks++; if (mif.md2ex_we_o !== 1'b0) $display("FAIL reset_we got %b exp 0", mif.md2ex_we_o); else n_pass++;
        n_checks++; if (mif.md2ex_busy_o !== 1'b0) $display("FAIL reset_busy got %b exp 0", mif.md2ex_busy_o); else n_pass++;
        n_checks++; if (mif.md2ex_result_o !== 32'h0) $display("FAIL reset_result got %h exp 0", mif.md2ex_result_o); else n_pass++;
        n_checks++; if (mif.md2ex_rd_addr_o !== 5'h0) $display("FAIL reset_rd got %h exp 0", mif.md2ex_rd_addr_o); else n_pass++;
        @(posedge clk); #1;
        bubble();
        rest = 1'b1;
    endtask

    task automatic test_plan();
        int st, we, wc; logic [31:0] res; logic [4:0] rdo; logic bf;
        plan = '{
            '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33},
            '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, 33},
            '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 33},
            '{3'd2, 32'hFFFF_FFFF,  32'd2,         5'd3,  32'hFFFF_FFFF, 33},
            '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 33},
            '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 33},
            '{3'd5, 32'd100,        32'd7,         5'd8,  32'd14,        33},
            '{3'd7, 32'd100,        32'd7,         5'd9,  32'd2,         33},
            '{3'd5, 32'd5,          32'd0,         5'd10, 32'hFFFF_FFFF, 1},
            '{3'd7, 32'd5,          32'd0,         5'd11, 32'd5,         1},
            '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1},
            '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd31, 32'h0,         1}
        };
        for (int i = 0; i < 12; i++) begin
            do_op(OPC_OP, F7_M, plan[i].f3, plan[i].a, plan[i].b, plan[i].rd, st, we, wc, res, rdo, bf);
            n_checks++; if (st !== plan[i].stalls) $display("FAIL plan%0d_stalls got %0d exp %0d", i, st, plan[i].stalls); else n_pass++;
            n_checks++; if (we !== 1) $display("FAIL plan%0d_we_count got %0d exp 1", i, we); else n_pass++;
            n_checks++; if (wc !== plan[i].stalls + 1) $display("FAIL plan%0d_we_cycle got %0d exp %0d", i, wc, plan[i].stalls + 1); else n_pass++;
            n_checks++; if (res !== plan[i].exp) $display("FAIL plan%0d_result got %h exp %h", i, res, plan[i].exp); else n_pass++;
            n_checks++; if (rdo !== plan[i].rd) $display("FAIL plan%0d_rd got %0d exp %0d", i, rdo, plan[i].rd); else n_pass++;
            n_checks++; if (bf !== 1'b0) $display("FAIL plan%0d_busy_at_start got %b exp 0", i, bf); else n_pass++;
        end
    endtask

    task automatic test_flush();
        int st, we, wc, early_we, early_stall; logic [31:0] res; logic [4:0] rdo; logic bf;
        early_we = 0; early_stall = 0;
        @(posedge clk); #1;
        drive(OPC_OP, F7_M, 3'd0, 32'd5, 32'd6, 5'd3);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mif.md2cu_stall_o) early_stall++;
            if (mif.md2ex_we_o) early_we++;
        end
        @(posedge clk); #1;
        mif.cu2md_flush_i = 1'b1;
        @(negedge clk);
        n_checks++; if (early_stall !== 10) $display("FAIL flush_pre_stalls got %0d exp 10", early_stall); else n_pass++;
        n_checks++; if (early_we !== 0) $display("FAIL flush_pre_we got %0d exp 0", early_we); else n_pass++;
        n_checks++; if (mif.md2cu_stall_o !== 1'b0) $display("FAIL flush_stall got %b exp 0", mif.md2cu_stall_o); else n_pass++;
        n_checks++; if (mif.md2ex_we_o !== 1'b0) $display("FAIL flush_we got %b exp 0", mif.md2ex_we_o); else n_pass++;
        do_op(OPC_OP, F7_M, 3'd0, 32'd3, 32'd4, 5'd7, st, we, wc, res, rdo, bf);
        n_checks++; if (bf !== 1'b0) $display("FAIL flush_busy_after got %b exp 0", bf); else n_pass++;
        n_checks++; if (st !== 33) $display("FAIL flush_next_stalls got %0d exp 33", st); else n_pass++;
        n_checks++; if (we !== 1) $display("FAIL flush_next_we got %0d exp 1", we); else n_pass++;
        n_checks++; if (res !== 32'd12) $display("FAIL flush_next_result got %h exp 0000000c", res); else n_pass++;
        // flush while idle blocks a start; flush in DONE suppresses the strobe
        @(posedge clk); #1;
        drive(OPC_OP, F7_M, 3'd0, 32'd3, 32'd4, 5'd7);
        mif.cu2md_flush_i = 1'b1;
        @(negedge clk);
        n_checks++; if (mif.md2cu_stall_o !== 1'b0) $display("FAIL flush_idle_stall got %b exp 0", mif.md2cu_stall_o); else n_pass++;
        @(posedge clk); #1;
        bubble();
        @(negedge clk);
        n_checks++; if (mif.md2ex_busy_o !== 1'b0) $display("FAIL flush_idle_busy got %b exp 0", mif.md2ex_busy_o); else n_pass++;
        @(posedge clk); #1;
        drive(OPC_OP, F7_M, 3'd5, 32'd5, 32'd0, 5'd9);
        @(negedge clk);
        n_checks++; if (mif.md2cu_stall_o !== 1'b1) $display("FAIL flush_done_start_stall got %b exp 1", mif.md2cu_stall_o); else n_pass++;
        @(posedge clk); #1;
        bubble();
        mif.cu2md_flush_i = 1'b1;
        @(negedge clk);
        n_checks++; if (mif.md2ex_we_o !== 1'b0) $display("FAIL flush_done_we got %b exp 0", mif.md2ex_we_o); else n_pass++;
        @(posedge clk); #1;
        mif.cu2md_flush_i = 1'b0;
        @(negedge clk);
        n_checks++; if (mif.md2ex_we_o !== 1'b0 || mif.md2ex_busy_o !== 1'b0)
            $display("FAIL flush_done_after got we=%b busy=%b exp 0 0", mif.md2ex_we_o, mif.md2ex_busy_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int st, we, wc; logic [31:0] res; logic [4:0] rdo; logic bf;
        do_op(OPC_OP, F7_M, 3'd0, 32'd3, 32'd4, 5'd7, st, we, wc, res, rdo, bf);
        @(posedge clk); #1;
        drive(OPC_OP, F7_M, 3'd5, $urandom, 32'($urandom_range(1, 1000)), 5'd13);
        for (int c = 1; c <= 20; c++) @(negedge clk);
        @(posedge clk); #1;
        rest = 1'b0;
        @(negedge clk);
        n_checks++; if (mif.md2cu_stall_o !== 1'b0) $display("FAIL rstmid_stall_low got %b exp 0", mif.md2cu_stall_o); else n_pass++;
        @(posedge clk); #1;
        rest = 1'b1;
        bubble();
        @(negedge clk);
        n_checks++; if (mif.md2ex_result_o !== 32'h0) $display("FAIL rstmid_result got %h exp 0", mif.md2ex_result_o); else n_pass++;
        n_checks++; if (mif.md2ex_rd_addr_o !== 5'h0) $display("FAIL rstmid_rd got %h exp 0", mif.md2ex_rd_addr_o); else n_pass++;
        n_checks++; if (mif.md2ex_busy_o !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", mif.md2ex_busy_o); else n_pass++;
        n_checks++; if (mif.md2ex_we_o !== 1'b0 || mif.md2cu_stall_o !== 1'b0)
            $display("FAIL rstmid_we_stall got we=%b stall=%b exp 0 0", mif.md2ex_we_o, mif.md2cu_stall_o); else n_pass++;
    endtask

    task automatic test_non_m();
        int st, we, wc; logic [31:0] res; logic [4:0] rdo; logic bf;
        do_op(OPC_OP, F7_BASE, 3'd0, 32'd9, 32'd9, 5'd4, st, we, wc, res, rdo, bf);
        n_checks++; if (st !== 0 || we !== 0) $display("FAIL nonm_add got stalls=%0d we=%0d exp 0 0", st, we); else n_pass++;
        do_op(OPC_IMM, F7_M, 3'd4, 32'd9, 32'd3, 5'd4, st, we, wc, res, rdo, bf);
        n_checks++; if (st !== 0 || we !== 0) $display("FAIL nonm_imm got stalls=%0d we=%0d exp 0 0", st, we); else n_pass++;
        do_op(OPC_OP, 7'b0100000, 3'd0, 32'd9, 32'd3, 5'd4, st, we, wc, res, rdo, bf);
        n_checks++; if (st !== 0 || we !== 0) $display("FAIL nonm_sub got stalls=%0d we=%0d exp 0 0", st, we); else n_pass++;
    endtask

    task automatic test_random();
        int st, we, wc, es, ew; logic [31:0] res, a, b, exp_res; logic [4:0] rdo, rd; logic bf;
        logic [2:0] f3;
        for (int i = 0; i < 60; i++) begin
            f3      = 3'($urandom_range(0, 7));
            a       = pick();
            b       = pick();
            rd      = 5'($urandom_range(0, 31));
            exp_res = ref_result(f3, a, b);
            es      = ref_special(f3, a, b) ? 1 : 33;
            ew      = (rd != 0) ? 1 : 0;
            do_op(OPC_OP, F7_M, f3, a, b, rd, st, we, wc, res, rdo, bf);
            n_checks++; if (st !== es) $display("FAIL rand%0d_stalls f3=%0d a=%h b=%h got %0d exp %0d", i, f3, a, b, st, es); else n_pass++;
            n_checks++; if (we !== ew) $display("FAIL rand%0d_we rd=%0d got %0d exp %0d", i, rd, we, ew); else n_pass++;
            if (rd != 0) begin
                n_checks++; if (res !== exp_res) $display("FAIL rand%0d_result f3=%0d a=%h b=%h got %h exp %h", i, f3, a, b, res, exp_res); else n_pass++;
                n_checks++; if (rdo !== rd) $display("FAIL rand%0d_rd got %0d exp %0d", i, rdo, rd); else n_pass++;
                n_checks++; if (wc !== es + 1) $display("FAIL rand%0d_we_cycle got %0d exp %0d", i, wc, es + 1); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_plan();
        test_flush();
        test_reset_mid();
        test_non_m();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached after %0d checks", n_checks);
        $fatal(1);
    end

endmodule
